// File: rtl/fft_r4_ctrl.sv
// Radix-4 DIF FFT sequencer. One BF4 butterfly is issued per cycle over all
// stages of an N = 4^LOG4N in-place transform. Write-back addresses follow
// the reads PIPE_LAT cycles later, and the datapath is drained between stages.
// Optional issue stall: define FFT_R4_CTRL_HOLD_EN to get the hold port.
module fft_r4_ctrl #(
  parameter int LOG4N    = 3,
  parameter int AW       = 2 * LOG4N,
  parameter int PIPE_LAT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
`ifdef FFT_R4_CTRL_HOLD_EN
  input  logic          hold,
`endif
  output logic          busy,
  output logic          done,
  output logic [1:0]    stage,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr0,
  output logic [AW-1:0] rd_addr1,
  output logic [AW-1:0] rd_addr2,
  output logic [AW-1:0] rd_addr3,
  output logic [AW-1:0] tw_exp,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr0,
  output logic [AW-1:0] wr_addr1,
  output logic [AW-1:0] wr_addr2,
  output logic [AW-1:0] wr_addr3
);

  // The butterfly counter needs AW-2 bits; N=4 keeps a 1-bit counter stuck at 0.
  localparam int            BW     = (AW > 2) ? AW - 2 : 1;
  localparam logic [BW-1:0] B_LAST = BW'((1 << (AW - 2)) - 1);
  localparam logic [1:0]    S_LAST = 2'(LOG4N - 1);
  localparam logic [2:0]    F_LAST = 3'(PIPE_LAT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] b_q, b_d;
  logic [1:0]    s_q, s_d;
  logic [2:0]    fcnt_q, fcnt_d;
  logic          issue;
  logic          hold_w;

  logic [AW-1:0] rd_d [4];
  logic [AW-1:0] tw_d;

  logic          busy_q, done_q, rd_en_q;
  logic [1:0]    stage_q;
  logic [AW-1:0] rd_q [4];
  logic [AW-1:0] tw_q;
  logic [PIPE_LAT-1:0] pv_q;
  logic [AW-1:0] pa_q [PIPE_LAT][4];

`ifdef FFT_R4_CTRL_HOLD_EN
  assign hold_w = hold;
`else
  assign hold_w = 1'b0;
`endif

  // Leg m address: the 2-bit digit at position p (p = LOG4N-1-s) is the leg
  // index, the butterfly counter fills the remaining digits around it.
  function automatic logic [AW-1:0] addr_f(input logic [1:0] m, input logic [BW-1:0] b,
                                           input logic [1:0] s);
    int            p2;
    logic [AW-1:0] bx, lo;
    p2 = 2 * (LOG4N - 1 - int'(s));
    bx = AW'(b);
    lo = AW'((1 << p2) - 1);
    addr_f = ((bx >> p2) << (p2 + 2)) | (AW'(m) << p2) | (bx & lo);
  endfunction

  // Twiddle base exponent: low digits of b scaled by 4^s, wrapped mod N.
  function automatic logic [AW-1:0] tw_f(input logic [BW-1:0] b, input logic [1:0] s);
    int            p2;
    logic [AW-1:0] bx, lo;
    p2 = 2 * (LOG4N - 1 - int'(s));
    bx = AW'(b);
    lo = AW'((1 << p2) - 1);
    tw_f = (bx & lo) << (2 * int'(s));
  endfunction

  // Sequencer next state: issue per RUN cycle, fixed-length drain per stage.
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    s_d     = s_q;
    fcnt_d  = fcnt_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          b_d     = '0;
          s_d     = '0;
        end
      end
      ST_RUN: begin
        if (!hold_w) begin
          issue = 1'b1;
          if (b_q == B_LAST) begin
            b_d     = '0;
            fcnt_d  = '0;
            state_d = ST_FLUSH;
          end else begin
            b_d = b_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        // Leaving here lets the next stage's first read land one cycle after
        // the previous stage's last write-back.
        if (fcnt_q == F_LAST) begin
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_RUN;
            s_d     = s_q + 2'd1;
          end
        end else begin
          fcnt_d = fcnt_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address and twiddle for the butterfly currently pointed to by b.
  always_comb begin
    for (int m = 0; m < 4; m++) rd_d[m] = addr_f(2'(m), b_q, s_q);
    tw_d = tw_f(b_q, s_q);
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      b_q     <= '0;
      s_q     <= '0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      s_q     <= s_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Registered outputs and the fixed-latency write-back address pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      stage_q <= '0;
      rd_en_q <= 1'b0;
      tw_q    <= '0;
      pv_q    <= '0;
      for (int m = 0; m < 4; m++) rd_q[m] <= '0;
      for (int k = 0; k < PIPE_LAT; k++)
        for (int m = 0; m < 4; m++) pa_q[k][m] <= '0;
    end else begin
      busy_q  <= (state_q == ST_RUN) || (state_q == ST_FLUSH);
      done_q  <= (state_q == ST_DONE);
      stage_q <= s_q;
      rd_en_q <= issue;
      // Under hold the addresses still track the pending butterfly.
      if (state_q == ST_RUN) begin
        for (int m = 0; m < 4; m++) rd_q[m] <= rd_d[m];
        tw_q <= tw_d;
      end
      // Shifts every cycle, hold included: the datapath latency is fixed.
      pv_q[0] <= rd_en_q;
      for (int m = 0; m < 4; m++) pa_q[0][m] <= rd_q[m];
      for (int k = 1; k < PIPE_LAT; k++) begin
        pv_q[k] <= pv_q[k-1];
        for (int m = 0; m < 4; m++) pa_q[k][m] <= pa_q[k-1][m];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign stage    = stage_q;
  assign rd_en    = rd_en_q;
  assign rd_addr0 = rd_q[0];
  assign rd_addr1 = rd_q[1];
  assign rd_addr2 = rd_q[2];
  assign rd_addr3 = rd_q[3];
  assign tw_exp   = tw_q;
  assign wr_en    = pv_q[PIPE_LAT-1];
  assign wr_addr0 = pa_q[PIPE_LAT-1][0];
  assign wr_addr1 = pa_q[PIPE_LAT-1][1];
  assign wr_addr2 = pa_q[PIPE_LAT-1][2];
  assign wr_addr3 = pa_q[PIPE_LAT-1][3];

endmodule

// File: tb/tb_fft_r4_ctrl.sv
// Self-checking bench for fft_r4_ctrl (N=64, PIPE_LAT=2). A schedule model
// built from the digit/twiddle rules predicts every cycle of a transform.
module tb_fft_r4_ctrl;
  localparam int LOG4N = 3;
  localparam int AW    = 6;
  localparam int PL    = 2;
  localparam int N     = 64;
  localparam int NB    = 16;
  localparam int MAXC  = 512;
`ifdef FFT_R4_CTRL_HOLD_EN
  localparam int FIX_DONE = 59;
`else
  localparam int FIX_DONE = 55;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
`ifdef FFT_R4_CTRL_HOLD_EN
  logic hold = 1'b0;
`endif
  logic          busy, done, rd_en, wr_en;
  logic [1:0]    stage;
  logic [AW-1:0] rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_exp;
  logic [AW-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;

  int n_cmp = 0;
  int n_fail = 0;

  bit exp_rd [MAXC];
  bit exp_wr [MAXC];
  bit has_a  [MAXC];
  bit held   [MAXC];
  int exp_a  [MAXC][4];
  int exp_wa [MAXC][4];
  int exp_tw [MAXC];
  int exp_st [MAXC];
  int done_exp;

  always #5 clk = ~clk;

  fft_r4_ctrl #(.LOG4N(LOG4N), .AW(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef FFT_R4_CTRL_HOLD_EN
    .hold(hold),
`endif
    .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
    .rd_addr0(rd_addr0), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .tw_exp(tw_exp), .wr_en(wr_en),
    .wr_addr0(wr_addr0), .wr_addr1(wr_addr1), .wr_addr2(wr_addr2), .wr_addr3(wr_addr3)
  );

  function automatic int pow4(input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = r * 4;
    return r;
  endfunction

  // Expected addresses/twiddle of butterfly b in stage s, shown at cycle c.
  task automatic fill(input int c, input int s, input int b);
    int p4;
    p4 = pow4(LOG4N - 1 - s);
    has_a[c] = 1'b1;
    for (int m = 0; m < 4; m++) exp_a[c][m] = (b / p4) * (p4 * 4) + m * p4 + (b % p4);
    exp_tw[c] = ((b % p4) * pow4(s)) % N;
    exp_st[c] = s;
  endtask

  // Schedule: one issue per cycle unless held, drain gap of PL cycles per stage.
  task automatic build_model();
    int cyc;
    for (int i = 0; i < MAXC; i++) begin
      exp_rd[i] = 1'b0; exp_wr[i] = 1'b0; has_a[i] = 1'b0;
    end
    cyc = 1;
    for (int s = 0; s < LOG4N; s++) begin
      for (int b = 0; b < NB; b++) begin
        while (held[cyc]) begin
          fill(cyc, s, b);
          cyc++;
        end
        fill(cyc, s, b);
        exp_rd[cyc] = 1'b1;
        exp_wr[cyc + PL] = 1'b1;
        exp_wa[cyc + PL] = exp_a[cyc];
        cyc++;
      end
      cyc = cyc + PL;
    end
    done_exp = cyc;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, stage, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_exp, wr_en,
           wr_addr0, wr_addr1, wr_addr2, wr_addr3} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cyc=%0d busy=%b done=%b rd_en=%b wr_en=%b want all 0",
                 i, busy, done, rd_en, wr_en);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({busy, done, stage, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_exp, wr_en,
           wr_addr0, wr_addr1, wr_addr2, wr_addr3} !== '0) begin
        n_fail++;
        $display("FAIL idle_outputs cyc=%0d busy=%b done=%b rd_en=%b wr_en=%b want all 0",
                 i, busy, done, rd_en, wr_en);
      end
    end
  endtask

  task automatic test_addr_tw();
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 56; cyc++) begin
      if (cyc > 1) @(negedge clk);
      @(posedge clk); #1;
      if (cyc == 6 || cyc == 24 || cyc == 42) begin
        int ea [4];
        int et;
        if (cyc == 6)       begin ea = '{5, 21, 37, 53}; et = 5; end
        else if (cyc == 24) begin ea = '{17, 21, 25, 29}; et = 4; end
        else                begin ea = '{20, 21, 22, 23}; et = 0; end
        n_cmp++;
        if (rd_en !== 1'b1 || 32'(rd_addr0) !== ea[0] || 32'(rd_addr1) !== ea[1] ||
            32'(rd_addr2) !== ea[2] || 32'(rd_addr3) !== ea[3] || 32'(tw_exp) !== et) begin
          n_fail++;
          $display("FAIL addr_tw_b5 cyc=%0d got rd=%b %0d,%0d,%0d,%0d tw=%0d want 1 %0d,%0d,%0d,%0d tw=%0d",
                   cyc, rd_en, rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_exp,
                   ea[0], ea[1], ea[2], ea[3], et);
        end
      end
      n_cmp++;
      if (done !== (cyc == 55)) begin
        n_fail++;
        $display("FAIL done_time cyc=%0d got %b want %b", cyc, done, (cyc == 55));
      end
    end
  endtask

  task automatic test_model_runs(input int nruns);
    int obs_done;
    for (int r = 0; r < nruns; r++) begin
      for (int i = 0; i < MAXC; i++) held[i] = 1'b0;
`ifdef FFT_R4_CTRL_HOLD_EN
      if (r == 0) begin
        for (int i = 8; i < 12; i++) held[i] = 1'b1;
      end else begin
        for (int i = 1; i < 300; i++) held[i] = ($urandom_range(3) == 0);
      end
`endif
      build_model();
      repeat ($urandom_range(3)) @(negedge clk);
      @(negedge clk); start = 1'b1;
      @(posedge clk);
      obs_done = -1;
      for (int cyc = 1; cyc <= done_exp + 2; cyc++) begin
        @(negedge clk);
        start = (cyc <= done_exp && r != 0) ? ($urandom_range(7) == 0) : 1'b0;
`ifdef FFT_R4_CTRL_HOLD_EN
        hold = held[cyc];
`endif
        @(posedge clk); #1;
        if (done === 1'b1 && obs_done < 0) obs_done = cyc;
        n_cmp++;
        if (rd_en !== exp_rd[cyc] || wr_en !== exp_wr[cyc] ||
            busy !== (cyc < done_exp) || done !== (cyc == done_exp)) begin
          n_fail++;
          $display("FAIL strobes run=%0d cyc=%0d got rd=%b wr=%b busy=%b done=%b want %b %b %b %b",
                   r, cyc, rd_en, wr_en, busy, done, exp_rd[cyc], exp_wr[cyc],
                   (cyc < done_exp), (cyc == done_exp));
        end
        if (has_a[cyc]) begin
          n_cmp++;
          if (32'(rd_addr0) !== exp_a[cyc][0] || 32'(rd_addr1) !== exp_a[cyc][1] ||
              32'(rd_addr2) !== exp_a[cyc][2] || 32'(rd_addr3) !== exp_a[cyc][3] ||
              32'(tw_exp) !== exp_tw[cyc]) begin
            n_fail++;
            $display("FAIL rd_addr run=%0d cyc=%0d got %0d,%0d,%0d,%0d tw=%0d want %0d,%0d,%0d,%0d tw=%0d",
                     r, cyc, rd_addr0, rd_addr1, rd_addr2, rd_addr3, tw_exp,
                     exp_a[cyc][0], exp_a[cyc][1], exp_a[cyc][2], exp_a[cyc][3], exp_tw[cyc]);
          end
        end
        if (exp_rd[cyc]) begin
          n_cmp++;
          if (32'(stage) !== exp_st[cyc]) begin
            n_fail++;
            $display("FAIL stage run=%0d cyc=%0d got %0d want %0d", r, cyc, stage, exp_st[cyc]);
          end
        end
        if (exp_wr[cyc]) begin
          n_cmp++;
          if (32'(wr_addr0) !== exp_wa[cyc][0] || 32'(wr_addr1) !== exp_wa[cyc][1] ||
              32'(wr_addr2) !== exp_wa[cyc][2] || 32'(wr_addr3) !== exp_wa[cyc][3]) begin
            n_fail++;
            $display("FAIL wr_addr run=%0d cyc=%0d got %0d,%0d,%0d,%0d want %0d,%0d,%0d,%0d",
                     r, cyc, wr_addr0, wr_addr1, wr_addr2, wr_addr3,
                     exp_wa[cyc][0], exp_wa[cyc][1], exp_wa[cyc][2], exp_wa[cyc][3]);
          end
        end
      end
      start = 1'b0;
`ifdef FFT_R4_CTRL_HOLD_EN
      hold = 1'b0;
`endif
      if (r == 0) begin
        n_cmp++;
        if (obs_done !== FIX_DONE) begin
          n_fail++;
          $display("FAIL done_cycle_fixed got %0d want %0d", obs_done, FIX_DONE);
        end
      end
    end
  endtask

  task automatic test_restart();
    int obs_done;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc <= 57; cyc++) begin
      @(negedge clk);
      start = (cyc == 10 || cyc == 55 || cyc == 56);
      @(posedge clk); #1;
      if (cyc == 11) begin
        n_cmp++;
        if (rd_en !== 1'b1 || 32'(rd_addr0) !== 10 || stage !== 2'd0) begin
          n_fail++;
          $display("FAIL start_while_busy cyc=11 got rd=%b addr0=%0d stage=%0d want 1 10 0",
                   rd_en, rd_addr0, stage);
        end
      end
      if (cyc == 55 || cyc == 56) begin
        n_cmp++;
        if (done !== (cyc == 55) || busy !== 1'b0 || rd_en !== 1'b0) begin
          n_fail++;
          $display("FAIL start_in_done cyc=%0d got done=%b busy=%b rd=%b want %b 0 0",
                   cyc, done, busy, rd_en, (cyc == 55));
        end
      end
      if (cyc == 57) begin
        n_cmp++;
        if (rd_en !== 1'b1 || busy !== 1'b1 || 32'(rd_addr0) !== 0 || stage !== 2'd0) begin
          n_fail++;
          $display("FAIL restart cyc=57 got rd=%b busy=%b addr0=%0d stage=%0d want 1 1 0 0",
                   rd_en, busy, rd_addr0, stage);
        end
      end
    end
    start = 1'b0;
    obs_done = -1;
    for (int i = 58; i <= 130 && obs_done < 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) obs_done = i;
    end
    n_cmp++;
    if (obs_done !== 111) begin
      n_fail++;
      $display("FAIL restart_done got %0d want 111", obs_done);
    end
  endtask

  task automatic test_reset_mid();
    int obs_done;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (19) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL mid_reset i=%0d got rd=%b wr=%b busy=%b want 0 0 0", i, rd_en, wr_en, busy);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (rd_en !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle i=%0d got rd=%b wr=%b busy=%b want 0 0 0", i, rd_en, wr_en, busy);
      end
    end
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (rd_en !== 1'b1 || stage !== 2'd0 || 32'(rd_addr0) !== 0 || 32'(rd_addr1) !== 16 ||
        32'(tw_exp) !== 0) begin
      n_fail++;
      $display("FAIL rerun_first got rd=%b stage=%0d addr0=%0d addr1=%0d tw=%0d want 1 0 0 16 0",
               rd_en, stage, rd_addr0, rd_addr1, tw_exp);
    end
    obs_done = -1;
    for (int i = 2; i <= 80 && obs_done < 0; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) obs_done = i;
    end
    n_cmp++;
    if (obs_done !== 55) begin
      n_fail++;
      $display("FAIL rerun_done got %0d want 55", obs_done);
    end
  endtask

  initial begin
    test_reset();
    test_addr_tw();
    test_model_runs(4);
    test_restart();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fft_r4_ctrl.md
# fft_r4_ctrl

In-place radix-4 DIF FFT sequencer that time-multiplexes one combinational 4-input butterfly datapath (BF4) over all stages of an N = 4^LOG4N point transform held in a 4-port sample RAM. Per cycle it issues one butterfly: four read addresses and a twiddle exponent. It then issues the matching in-place write-back a fixed pipeline latency later. Between stages it drains the datapath pipeline so the next stage never reads stale data. It sits between the frame-level OFDM control (start/done) and the BF4/twiddle/RAM datapath.

## Interface
- LOG4N, 3, radix-4 stage count; N = 4^LOG4N; legal 1..4
- AW, 2*LOG4N, sample address width
- PIPE_LAT, 2, cycles from rd_en to the corresponding wr_en (RAM read + BF4 + twiddle mult); legal 1..8
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to run a full transform; ignored unless idle
- hold  in  1  stalls butterfly issue while high (only with FFT_R4_CTRL_HOLD_EN)
- busy  out  1  high from first issue until last write completes
- done  out  1  one-cycle pulse after final write-back
- stage  out  2  current stage index 0..LOG4N-1, aligned with rd_en
- rd_en  out  1  butterfly read strobe
- rd_addr0..rd_addr3  out  AW each  read addresses for butterfly legs m=0..3
- tw_exp  out  AW  twiddle base exponent k; datapath applies W_N^(m*k) to leg m
- wr_en  out  1  write-back strobe
- wr_addr0..wr_addr3  out  AW each  write addresses (equal to the read addresses issued PIPE_LAT cycles earlier)

## Operation
- All outputs registered; reset value 0 for every output, FSM = IDLE, counters 0, write pipeline valid bits cleared.
- FSM: IDLE -> RUN on start; RUN -> FLUSH after issuing butterfly b = N/4-1; FLUSH -> RUN (stage+1) when write pipeline empty and stage < LOG4N-1; FLUSH -> DONE when empty and stage = LOG4N-1; DONE -> IDLE unconditionally.
- Butterfly counter b, width AW-2, increments per issue and wraps to 0 at the stage boundary.
- Address rule, stage s, p = LOG4N-1-s: rd_addrm = {b[AW-3:2p], m[1:0], b[2p-1:0]}, where the upper field is empty when p = LOG4N-1 and the lower field is empty when p = 0.
- Twiddle rule: tw_exp = (b[2p-1:0] << 2s) mod N; always 0 in the last stage.
- Write pipeline: PIPE_LAT-deep shift register of {valid, 4 addresses}. It shifts every cycle, including under hold, because the datapath has fixed latency.
- busy = (state is RUN or FLUSH). done is high only in DONE, with busy low.
- start while busy or in DONE: ignored, not queued.
- rst_n low mid-transform: aborts next edge, with no further rd_en or wr_en. Pipeline writes in flight are discarded.
- Output order is digit-reversed; reordering is downstream.

## Timing
- Samples start high in IDLE at edge t: first rd_en at t+1, with b=0 and stage=0.
- With no hold, rd_en stays high for N/4 consecutive cycles per stage.
- wr_en for an issue at cycle c appears at c+PIPE_LAT.
- Next stage's first rd_en is at (last issue of the stage) + PIPE_LAT + 1. There is no read/write overlap across stages.
- Cycle count from start: done pulses at t + LOG4N*(N/4+PIPE_LAT) + 1. For N=64 and PIPE_LAT=2 that is t+55, with busy high t+1..t+54.
- hold high at edge: rd_en low that cycle; b, stage and addresses are frozen. Issue resumes the cycle after hold drops.
- hold during FLUSH: no effect.

## Configuration
- FFT_R4_CTRL_HOLD_EN defined: the hold port exists and stalls issue as above.
- Not defined: no hold port, and issue never stalls.
- Without the macro, cycle timing must match the macro-enabled build with hold tied 0.

## Test plan
- Reset/idle: rst_n=0 for 3 cycles, then idle 5 cycles -> all outputs 0; start asserted while rst_n=0 -> no activity.
- Address/twiddle check, N=64, PIPE_LAT=2, start at t. Expected values at b=5:
  - stage 0: addrs 5, 21, 37, 53, tw_exp=5
  - stage 1: addrs 17, 21, 25, 29, tw_exp=4
  - stage 2: addrs 20, 21, 22, 23, tw_exp=0
- Full run timing: single start pulse -> rd_en windows t+1..t+16, t+19..t+34 and t+37..t+52; wr_en windows t+3..t+18, t+21..t+36 and t+39..t+54; done at t+55 only.
- Hold (macro on): hold=1 for 4 cycles at stage 0, b=7 -> rd_en low 4 cycles with rd_addr0 held at 7; then b=7 issues; done delayed by exactly 4 cycles, to t+59.
- start re-asserted at t+10 and t+55 -> no effect at t+10. The t+55 start is sampled in DONE and ignored; a new start at t+56 begins a run at t+57.
- rst_n=0 at t+20 -> rd_en, wr_en and busy are 0 from t+21. A subsequent start runs from stage 0, b=0.
